pe_sequencer: RTL and testbench

PE_SEQUENCER -- requirements
Module: pe_sequencer

---
 rtl/pe_sequencer_pkg.sv | 15 +
 rtl/pe_res_fifo.sv | 64 ++++++
 rtl/pe_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pe_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_sequencer_pkg.sv
// Shared types and widths for the PE sequencer and its result FIFO.
package pe_sequencer_pkg;

  localparam int unsigned STEP_W   = 3;
  localparam int unsigned BOUND_W  = 3;
  localparam int unsigned PE_OUT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pe_res_fifo.sv
// Result FIFO: power-of-two depth, simultaneous push/pop allowed even when full.
module pe_res_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head is leaving in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pe_sequencer.sv
// Job sequencer: issues credit-limited PE bursts per pixel and buffers PE results.
module pe_sequencer
  import pe_sequencer_pkg::*;
#(
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [STEP_W-1:0]   cfg_step,
  input  logic [BOUND_W-1:0]  cfg_bound,
  input  logic [CNT_W-1:0]    cfg_npix,
  input  logic                fetch_ready,
  output logic                fetch_valid,
  output logic                pe_en,
  output logic [STEP_W-1:0]   pe_step,
  output logic [BOUND_W-1:0]  pe_bound,
  input  logic                pe_out_en,
  input  logic [PE_OUT_W-1:0] pe_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PE_OUT_W-1:0] res_data,
  output logic                res_last,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CW = $clog2(RES_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  state_e               state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [BOUND_W-1:0]   bound_q, bound_d;
  logic [CNT_W-1:0]     npix_q, npix_d;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic [CNT_W-1:0]     results_q, results_d;
  logic [STEP_W-1:0]    beat_q, beat_d;
  logic [CW-1:0]        inflight_q, inflight_d;
  logic                 err_q, err_d;

  logic                 start, accept_res, credit_ok;
  logic [OW-1:0]        occ;
  logic                 fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0]        fifo_count;
  logic [PE_OUT_W:0]    fifo_head, fifo_in;

  assign accept_res = pe_out_en && (state_q != IDLE);
  assign fifo_pop   = !fifo_empty && res_ready;
  assign occ        = OW'(fifo_count) + OW'(inflight_q);
  assign credit_ok  = occ < OW'(RES_DEPTH);
  assign fifo_in    = {(results_q + 1'b1 == npix_q), pe_out};

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    bound_d    = bound_q;
    npix_d     = npix_q;
    issued_d   = issued_q;
    results_d  = results_q;
    beat_d     = beat_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    start      = 1'b0;
    done       = 1'b0;
    fifo_push  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          step_d    = cfg_step;
          bound_d   = cfg_bound;
          npix_d    = cfg_npix;
          issued_d  = '0;
          results_d = '0;
          state_d   = (cfg_npix == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // beat_q counts beats still owed after this cycle, so a new burst can
        // start in the cycle right after the previous burst's last beat.
        start = fetch_ready && credit_ok && (beat_q == '0) && (issued_q != npix_q);
        if ((issued_q == npix_q) && (beat_q == '0)) state_d = DRAIN;
      end
      DRAIN: begin
        if ((inflight_q == '0) && fifo_empty) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      beat_d   = step_q;
      issued_d = issued_q + 1'b1;
    end else if (beat_q != '0) begin
      beat_d = beat_q - 1'b1;
    end

    case ({start, accept_res && (inflight_q != '0)})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    if (accept_res) begin
      results_d = results_q + 1'b1;
      if (fifo_full && !fifo_pop) err_d = 1'b1;
      else                        fifo_push = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      step_q     <= '0;
      bound_q    <= '0;
      npix_q     <= '0;
      issued_q   <= '0;
      results_q  <= '0;
      beat_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      bound_q    <= bound_d;
      npix_q     <= npix_d;
      issued_q   <= issued_d;
      results_q  <= results_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  pe_res_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (PE_OUT_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (fifo_push),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign pe_en       = start || (beat_q != '0);
  assign fetch_valid = pe_en;
  assign pe_step     = step_q;
  assign pe_bound    = bound_q;
  assign cfg_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign res_valid   = !fifo_empty;
  assign res_data    = fifo_head[PE_OUT_W-1:0];
  assign res_last    = fifo_head[PE_OUT_W] && !fifo_empty;

endmodule

// File: tb/tb_pe_sequencer.sv
// Scoreboard bench for pe_sequencer with a latency-modelled PE and random traffic.
module tb_pe_sequencer;
  import pe_sequencer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [STEP_W-1:0]   cfg_step = '0;
  logic [BOUND_W-1:0]  cfg_bound = '0;
  logic [CNTW-1:0]     cfg_npix = '0;
  logic                fetch_ready = 1'b0;
  logic                fetch_valid;
  logic                pe_en;
  logic [STEP_W-1:0]   pe_step;
  logic [BOUND_W-1:0]  pe_bound;
  logic                pe_out_en = 1'b0;
  logic [PE_OUT_W-1:0] pe_out = '0;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [PE_OUT_W-1:0] res_data;
  logic                res_last;
  logic                busy;
  logic                done;

  pe_sequencer #(.RES_DEPTH(DEPTH), .CNT_W(CNTW)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_step(cfg_step), .cfg_bound(cfg_bound), .cfg_npix(cfg_npix),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .pe_en(pe_en), .pe_step(pe_step), .pe_bound(pe_bound),
    .pe_out_en(pe_out_en), .pe_out(pe_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;
  logic [8:0] sb_q[$];
  int due_q[$];
  int job_step, job_bound, job_npix, pe_lat, acc_cyc, done_cyc;
  int started, popped, beats, bcnt, run_len, max_run, done_cnt, exp_res_cnt, extra_res, vld_seen;
  int fr_pct = 100, rr_pct = 100, fr_low = 0, inject = 0;
  bit drop_arm = 1'b0, cfg_req = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result monitor: every accepted result must match the head of the scoreboard.
  always @(negedge clk) begin
    #2;
    if (reset && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        check("res_spurious", int'(res_valid), 0);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        check("res_data", int'(res_data), int'(e[7:0]));
        check("res_last", int'(res_last), int'(e[8]));
      end
      popped++;
    end
  end

  task automatic clear_model();
    sb_q.delete(); due_q.delete();
    job_step = 0; job_bound = 0; job_npix = 0; pe_lat = 1;
    acc_cyc = 1 << 30; done_cyc = 0;
    started = 0; popped = 0; beats = 0; bcnt = 0; run_len = 0; max_run = 0;
    done_cnt = 0; exp_res_cnt = 0; extra_res = 0; vld_seen = 0;
    fr_low = 0; drop_arm = 1'b0; inject = 0;
  endtask

  task automatic push_result();
    pe_out_en = 1'b1;
    pe_out = 8'($urandom);
    exp_res_cnt++;
    sb_q.push_back({(exp_res_cnt == job_npix), pe_out});
  endtask

  task automatic step_cycle();
    @(negedge clk);
    cyc++;
    cfg_valid = cfg_req;
    cfg_step  = 3'(job_step);
    cfg_bound = 3'(job_bound);
    cfg_npix  = CNTW'(job_npix);
    pe_out_en = 1'b0;
    pe_out    = '0;
    if (inject == 1) begin
      push_result();
    end else if (inject == 2) begin
      pe_out_en = 1'b1;
      pe_out = 8'($urandom);
    end else if (due_q.size() != 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      push_result();
    end
    inject = 0;
    if (fr_low > 0) begin
      fetch_ready = 1'b0;
      fr_low--;
    end else begin
      fetch_ready = ($urandom_range(99) < fr_pct);
    end
    res_ready = ($urandom_range(99) < rr_pct);
    #1;
    if (res_valid) vld_seen++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_busy", int'(busy), 1);
    end
    check("fetch_valid", int'(fetch_valid), int'(pe_en));
    if (busy && cyc > acc_cyc) begin
      check("pe_step", int'(pe_step), job_step);
      check("pe_bound", int'(pe_bound), job_bound);
    end
    if (bcnt != 0) check("burst_contig", int'(pe_en), 1);
    if (pe_en) begin
      if (bcnt == 0) begin
        check("start_fetch_ready", int'(fetch_ready), 1);
        check("start_credit", int'((started - popped) < int'(DEPTH)), 1);
        check("start_count", int'(started < job_npix), 1);
        started++;
      end
      bcnt++; beats++; run_len++;
      if (run_len > max_run) max_run = run_len;
      if (bcnt == job_step + 1) begin
        bcnt = 0;
        due_q.push_back(cyc + pe_lat);
      end
      if (drop_arm && bcnt == 1) begin
        drop_arm = 1'b0;
        fr_low = 5;
      end
    end else begin
      run_len = 0;
    end
  endtask

  task automatic start_job(input int s, input int b, input int n, input int lat);
    clear_model();
    job_step = s; job_bound = b; job_npix = n; pe_lat = lat;
    cfg_req = 1'b1;
    step_cycle();
    check("cfg_ready_accept", int'(cfg_ready), 1);
    cfg_req = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic finish_job(input int budget, input int expect_err);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step_cycle();
      n++;
    end
    check("done_seen", done_cnt, 1);
    step_cycle();
    step_cycle();
    check("cfg_ready_back", int'(cfg_ready), 1);
    check("busy_back", int'(busy), 0);
    check("done_once", done_cnt, 1);
    check("beats", beats, job_npix * (job_step + 1));
    check("results", exp_res_cnt, job_npix + extra_res);
    check("sb_empty", sb_q.size(), 0);
    check("err_flag", int'(dut.err_q), expect_err);
  endtask

  task automatic reset_checks();
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_pe_en", int'(pe_en), 0);
    check("rst_fetch_valid", int'(fetch_valid), 0);
    check("rst_pe_step", int'(pe_step), 0);
    check("rst_pe_bound", int'(pe_bound), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_last", int'(res_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(dut.err_q), 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    reset_checks();
    @(negedge clk);
    reset = 1'b1;
    clear_model();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    clear_model();
    repeat (2) @(negedge clk);
    apply_reset();

    // Nominal three-pixel job: nine contiguous beats.
    start_job(2, 1, 3, 2);
    finish_job(200, 0);
    check("max_run_nominal", max_run, 9);

    // Empty job goes straight to DONE.
    start_job(0, 0, 0, 1);
    finish_job(50, 0);
    check("npix0_done_lat", int'((done_cyc - acc_cyc) >= 1 && (done_cyc - acc_cyc) <= 2), 1);
    check("npix0_no_valid", vld_seen, 0);

    // Back-pressure: credit stalls issue at FIFO depth.
    start_job(0, 2, 8, 1);
    rr_pct = 0;
    repeat (40) step_cycle();
    check("stall_beats", beats, int'(DEPTH));
    check("stall_valid", int'(res_valid), 1);
    rr_pct = 100;
    finish_job(200, 0);

    // fetch_ready dropped mid-burst.
    start_job(3, 5, 3, 2);
    drop_arm = 1'b1;
    finish_job(300, 0);

    // Counter at its maximum.
    start_job(0, 7, (1 << CNTW) - 1, 1);
    finish_job(500, 0);

    // Reset during the first beat of a burst, then a fresh job.
    start_job(2, 3, 3, 2);
    n = 0;
    while (beats == 0 && n < 20) begin
      step_cycle();
      n++;
    end
    check("saw_first_beat", beats, 1);
    apply_reset();
    repeat (3) step_cycle();
    start_job(1, 2, 4, 3);
    finish_job(300, 0);

    // Push coinciding with pop on a full FIFO, then a real overflow.
    start_job(0, 1, 4, 1);
    rr_pct = 0;
    repeat (20) step_cycle();
    check("fifo_full_before", int'(dut.fifo_count), int'(DEPTH));
    inject = 1;
    extra_res = 1;
    rr_pct = 100;
    step_cycle();
    rr_pct = 0;
    step_cycle();
    check("fifo_full_after_pushpop", int'(dut.fifo_count), int'(DEPTH));
    check("err_after_pushpop", int'(dut.err_q), 0);
    inject = 2;
    step_cycle();
    step_cycle();
    check("err_after_overflow", int'(dut.err_q), 1);
    check("fifo_after_overflow", int'(dut.fifo_count), int'(DEPTH));
    rr_pct = 100;
    finish_job(200, 1);
    @(negedge clk);
    apply_reset();

    // Result strobe in IDLE is ignored.
    inject = 2;
    step_cycle();
    step_cycle();
    check("idle_res_valid", int'(res_valid), 0);
    check("idle_err", int'(dut.err_q), 0);

    // Random jobs.
    for (int j = 0; j < 15; j++) begin
      int rs, rb, rn, rl;
      rs = $urandom_range(7, 0);
      rb = $urandom_range(7, 0);
      rn = $urandom_range(15, 0);
      rl = $urandom_range(3, 1);
      start_job(rs, rb, rn, rl);
      fr_pct = $urandom_range(100, 40);
      rr_pct = $urandom_range(100, 30);
      finish_job(3000, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
